// File: rtl/sram_1rw1r.sv
module sram_1rw1r #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 10,
  parameter int    NUM_WMASKS   = DATA_WIDTH / 8,
  parameter int    READ_LATENCY = 1,
  parameter string IFILE        = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ready,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [NUM_WMASKS-1:0] p0_wmask,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic                  p0_rvalid,
  input  logic                  p1_req,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p1_rvalid
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  p0_wr;
  logic                  p0_rd;
  logic                  p1_rd;
  logic [DATA_WIDTH-1:0] p0_merged;
  logic [DATA_WIDTH-1:0] p1_word;

  assign p0_wr = p0_req & ready & p0_we;
  assign p0_rd = p0_req & ready & ~p0_we;
  assign p1_rd = p1_req & ready;

  always_comb begin
    p0_merged = mem[p0_addr];
    for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
      if (p0_wmask[i]) p0_merged[i*8 +: 8] = p0_wdata[i*8 +: 8];
    end
  end

  assign p1_word = (p0_wr && (p0_addr == p1_addr)) ? p0_merged : mem[p1_addr];

`ifdef SRAM_CLEAR_EN
  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] clear_ptr;
  logic [ADDR_WIDTH-1:0] clear_ptr_next;
  logic                  clear_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_CLEAR;
      clear_ptr <= '0;
    end else begin
      state     <= state_next;
      clear_ptr <= clear_ptr_next;
    end
  end

  always_comb begin
    state_next     = state;
    clear_ptr_next = clear_ptr;
    clear_we       = 1'b0;
    ready          = 1'b0;
    case (state)
      S_CLEAR: begin
        clear_we       = 1'b1;
        clear_ptr_next = clear_ptr + 1'b1;
        if (clear_ptr == '1) state_next = S_READY;
      end
      S_READY: ready = 1'b1;
      default: state_next = S_CLEAR;
    endcase
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready <= 1'b0;
    else        ready <= 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
`ifdef SRAM_CLEAR_EN
    if (clear_we) mem[clear_ptr] <= '0;
`endif
    if (p0_wr) begin
      for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
        if (p0_wmask[i]) mem[p0_addr][i*8 +: 8] <= p0_wdata[i*8 +: 8];
      end
    end
  end

  logic                  p0_v1;
  logic                  p1_v1;
  logic [DATA_WIDTH-1:0] p0_d1;
  logic [DATA_WIDTH-1:0] p1_d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_v1 <= 1'b0;
      p1_v1 <= 1'b0;
      p0_d1 <= '0;
      p1_d1 <= '0;
    end else begin
      p0_v1 <= p0_rd;
      p1_v1 <= p1_rd;
      if (p0_rd) p0_d1 <= mem[p0_addr];
      if (p1_rd) p1_d1 <= p1_word;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          p0_rvalid <= 1'b0;
          p1_rvalid <= 1'b0;
          p0_rdata  <= '0;
          p1_rdata  <= '0;
        end else begin
          p0_rvalid <= p0_v1;
          p1_rvalid <= p1_v1;
          if (p0_v1) p0_rdata <= p0_d1;
          if (p1_v1) p1_rdata <= p1_d1;
        end
      end
    end else begin : g_lat1
      assign p0_rvalid = p0_v1;
      assign p1_rvalid = p1_v1;
      assign p0_rdata  = p0_d1;
      assign p1_rdata  = p1_d1;
    end
  endgenerate

endmodule
